// File: rtl/ad7864_multi_drv.sv
// Multi-chip AD7864 acquisition sequencer: shared CONVST, BUSY wait, per-chip/channel reads, tagged samples.
// Optional BUSY-wait timeout is compiled in with `define AD7864_TIMEOUT_EN.
module ad7864_multi_drv #(
  parameter int CHIP_NO  = 4,
  parameter int CH_NUM   = 4,
  parameter int DATA_W   = 12,
  parameter int CONV_CYC = 2,
  parameter int RD_CYC   = 3,
  parameter int TMO_CYC  = 255
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               dsp_conv_bar,
  output logic               ad_conv_bar,
  output logic [CHIP_NO-1:0] ad_cs_bar,
  output logic               ad_rd_bar,
  output logic [3:0]         ad_sl,
  input  logic [CHIP_NO-1:0] ad_busy,
  input  logic [DATA_W-1:0]  ad_db,
  output logic [DATA_W-1:0]  smp_data,
  output logic [2:0]         smp_chip,
  output logic [1:0]         smp_ch,
  output logic               smp_vld,
  output logic               db_rdy,
  output logic               seq_busy,
  output logic               err_ovr,
  output logic               err_tmo
);

  localparam int CNT_M1 = (CONV_CYC > RD_CYC) ? CONV_CYC : RD_CYC;
  localparam int CNT_M2 = (CNT_M1 > TMO_CYC) ? CNT_M1 : TMO_CYC;
  localparam int CNT_W  = $clog2(CNT_M2 + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT_HI, WAIT_LO, CS_SETUP, READ, GAP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        chip_reg, chip_next;
  logic [1:0]        ch_reg, ch_next;
  logic              sync1_reg, sync2_reg, sync3_reg;
  logic              req, capture, frame_done, tmo_abort, tmo_hit, cs_act;
  logic [DATA_W-1:0] smp_data_reg;
  logic [2:0]        smp_chip_reg;
  logic [1:0]        smp_ch_reg;
  logic              smp_vld_reg, db_rdy_reg, seq_busy_reg, err_ovr_reg, err_tmo_reg;

  // sync3 is the edge register: a request is a falling edge of the synchronised input
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      sync3_reg <= 1'b1;
    end else begin
      sync1_reg <= dsp_conv_bar;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end
  assign req = sync3_reg & ~sync2_reg;

`ifdef AD7864_TIMEOUT_EN
  assign tmo_hit = (cnt_reg == CNT_W'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      chip_reg  <= '0;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      chip_reg  <= chip_next;
      ch_reg    <= ch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    chip_next  = chip_reg;
    ch_next    = ch_reg;
    capture    = 1'b0;
    frame_done = 1'b0;
    tmo_abort  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (req) state_next = CONV;
      end
      CONV: begin
        if (cnt_reg == CNT_W'(CONV_CYC - 1)) begin
          state_next = WAIT_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (|ad_busy) begin
          state_next = WAIT_LO;
          cnt_next   = '0;
        end else if (tmo_hit) begin
          state_next = IDLE;
          tmo_abort  = 1'b1;
        end else begin
`ifdef AD7864_TIMEOUT_EN
          cnt_next = cnt_reg + CNT_W'(1);
`endif
        end
      end
      WAIT_LO: begin
        if (~|ad_busy) begin
          state_next = CS_SETUP;
          cnt_next   = '0;
          chip_next  = '0;
          ch_next    = '0;
        end else if (tmo_hit) begin
          state_next = IDLE;
          tmo_abort  = 1'b1;
        end else begin
`ifdef AD7864_TIMEOUT_EN
          cnt_next = cnt_reg + CNT_W'(1);
`endif
        end
      end
      CS_SETUP: begin
        state_next = READ;
        cnt_next   = '0;
      end
      READ: begin
        if (cnt_reg == CNT_W'(RD_CYC - 1)) begin
          capture    = 1'b1;
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (ch_reg != 2'(CH_NUM - 1)) begin
          ch_next    = ch_reg + 2'd1;
          state_next = READ;
        end else if (chip_reg != 3'(CHIP_NO - 1)) begin
          chip_next  = chip_reg + 3'd1;
          ch_next    = '0;
          state_next = CS_SETUP;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      smp_data_reg <= '0;
      smp_chip_reg <= '0;
      smp_ch_reg   <= '0;
      smp_vld_reg  <= 1'b0;
      db_rdy_reg   <= 1'b0;
      seq_busy_reg <= 1'b0;
      err_ovr_reg  <= 1'b0;
      err_tmo_reg  <= 1'b0;
    end else begin
      smp_vld_reg <= capture;
      db_rdy_reg  <= frame_done;
      err_ovr_reg <= req && (state_reg != IDLE);
      err_tmo_reg <= tmo_abort;
      if (capture) begin
        smp_data_reg <= ad_db;
        smp_chip_reg <= chip_reg;
        smp_ch_reg   <= ch_reg;
      end
      if (state_reg == IDLE && req)   seq_busy_reg <= 1'b1;
      else if (frame_done || tmo_abort) seq_busy_reg <= 1'b0;
    end
  end

  // Strobes decode straight from the state register so reset releases them without waiting for a clock
  assign cs_act      = (state_reg == CS_SETUP) || (state_reg == READ) || (state_reg == GAP);
  assign ad_conv_bar = (state_reg != CONV);
  assign ad_rd_bar   = (state_reg != READ);

  generate
    for (genvar gi = 0; gi < CHIP_NO; gi++) begin : g_cs
      assign ad_cs_bar[gi] = ~(cs_act && (chip_reg == 3'(gi)));
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_sl
      assign ad_sl[gi] = (gi < CH_NUM) ? 1'b1 : 1'b0;
    end
  endgenerate

  assign smp_data = smp_data_reg;
  assign smp_chip = smp_chip_reg;
  assign smp_ch   = smp_ch_reg;
  assign smp_vld  = smp_vld_reg;
  assign db_rdy   = db_rdy_reg;
  assign seq_busy = seq_busy_reg;
  assign err_ovr  = err_ovr_reg;
  assign err_tmo  = err_tmo_reg;

endmodule

// File: tb/tb_ad7864_multi_drv.sv
// Bench for ad7864_multi_drv: BUSY/data-bus model per chip, expected-sample queue built per frame.
module tb_ad7864_multi_drv;
  localparam int CHIP_NO  = 4;
  localparam int CH_NUM   = 4;
  localparam int DATA_W   = 12;
  localparam int CONV_CYC = 2;
  localparam int RD_CYC   = 3;
  localparam int TMO_CYC  = 20;

  logic               clkin = 1'b0;
  logic               rst, dsp_conv_bar;
  logic               ad_conv_bar, ad_rd_bar;
  logic [CHIP_NO-1:0] ad_cs_bar, ad_busy;
  logic [3:0]         ad_sl;
  logic [DATA_W-1:0]  ad_db, smp_data;
  logic [2:0]         smp_chip;
  logic [1:0]         smp_ch;
  logic               smp_vld, db_rdy, seq_busy, err_ovr, err_tmo;

  ad7864_multi_drv #(
    .CHIP_NO(CHIP_NO), .CH_NUM(CH_NUM), .DATA_W(DATA_W),
    .CONV_CYC(CONV_CYC), .RD_CYC(RD_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .clkin(clkin), .rst(rst), .dsp_conv_bar(dsp_conv_bar),
    .ad_conv_bar(ad_conv_bar), .ad_cs_bar(ad_cs_bar), .ad_rd_bar(ad_rd_bar),
    .ad_sl(ad_sl), .ad_busy(ad_busy), .ad_db(ad_db),
    .smp_data(smp_data), .smp_chip(smp_chip), .smp_ch(smp_ch), .smp_vld(smp_vld),
    .db_rdy(db_rdy), .seq_busy(seq_busy), .err_ovr(err_ovr), .err_tmo(err_tmo)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [DATA_W-1:0] d;
    int chip;
    int ch;
  } smp_t;

  int checks = 0;
  int errors = 0;
  smp_t exp_q[$];
  logic [DATA_W-1:0] mem [CHIP_NO][4];
  int rd_idx [CHIP_NO];
  int tmr [CHIP_NO];
  int dur [CHIP_NO];
  int cyc = 0, last_vld = 0, frame_vld = 0;
  int n_rdy = 0, n_ovr = 0, n_tmo = 0, n_vld = 0;
  int rd_low = 0, conv_low = 0;
  logic conv_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data bus model: selected chip returns its next channel result on each read
  always_comb begin
    ad_db = '1;
    for (int c = 0; c < CHIP_NO; c++)
      if (!ad_cs_bar[c]) ad_db = mem[c][rd_idx[c] & 3];
  end

  always @(negedge clkin) begin
    int cs_low, sel;
    smp_t s;
    cyc++;
    if (rst) begin
      exp_q.delete();
      frame_vld = 0; rd_low = 0; conv_low = 0; conv_prev = 1'b1;
      for (int c = 0; c < CHIP_NO; c++) begin tmr[c] = -1; rd_idx[c] = 0; end
      ad_busy = '0;
    end else begin
      cs_low = 0; sel = 0;
      for (int c = 0; c < CHIP_NO; c++) if (!ad_cs_bar[c]) begin cs_low++; sel = c; end
      check("cs_onehot", 32'(cs_low <= 1), 1);
      if (!ad_rd_bar) begin
        check("rd_needs_cs", cs_low, 1);
        check("rd_busy_clear", 32'(ad_busy), 0);
        rd_low++;
      end else if (rd_low > 0) begin
        check("rd_width", rd_low, RD_CYC);
        rd_low = 0;
        rd_idx[sel]++;
      end
      if (!ad_conv_bar) conv_low++;
      else if (conv_low > 0) begin check("conv_width", conv_low, CONV_CYC); conv_low = 0; end
      // New frame: fresh chip data and the expected sample order
      if (conv_prev && !ad_conv_bar) begin
        exp_q.delete();
        frame_vld = 0;
        for (int c = 0; c < CHIP_NO; c++) begin
          rd_idx[c] = 0; tmr[c] = -1;
          for (int h = 0; h < 4; h++) mem[c][h] = DATA_W'($urandom);
          for (int h = 0; h < CH_NUM; h++) begin
            s.d = mem[c][h]; s.chip = c; s.ch = h;
            exp_q.push_back(s);
          end
        end
      end
      conv_prev = ad_conv_bar;
      if (smp_vld) begin
        n_vld++; frame_vld++; last_vld = cyc;
        if (exp_q.size() == 0) check("smp_unexpected", 1, 0);
        else begin
          s = exp_q.pop_front();
          $display("sample chip %0d ch %0d data %03h (model %03h)", smp_chip, smp_ch, smp_data, s.d);
          check("smp_data", 32'(smp_data), 32'(s.d));
          check("smp_chip", 32'(smp_chip), s.chip);
          check("smp_ch", 32'(smp_ch), s.ch);
        end
      end
      if (db_rdy) begin
        n_rdy++;
        $display("frame ready, %0d samples", frame_vld);
        check("rdy_vs_vld", 32'(smp_vld), 0);
        check("rdy_delay", cyc - last_vld, 2);
        check("frame_samples", frame_vld, CHIP_NO * CH_NUM);
        check("queue_empty", exp_q.size(), 0);
        check("busy_at_rdy", 32'(seq_busy), 0);
      end
      if (err_ovr) n_ovr++;
      if (err_tmo) begin n_tmo++; exp_q.delete(); end
      // BUSY model: rises 2 cycles after CONVST, stays high dur[c] cycles
      for (int c = 0; c < CHIP_NO; c++) begin
        if (!ad_conv_bar && tmr[c] < 0) tmr[c] = 0;
        else if (tmr[c] >= 0) tmr[c]++;
        ad_busy[c] = (tmr[c] >= 2) && (tmr[c] < 2 + dur[c]);
      end
    end
  end

  task automatic do_req(input bit measure);
    int n;
    @(posedge clkin); #1 dsp_conv_bar = 1'b0;
    if (measure) begin
      n = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clkin); #1 n++;
        if (!ad_conv_bar) break;
      end
      check("req_latency", n, 3);
    end
    repeat (4) @(posedge clkin);
    #1 dsp_conv_bar = 1'b1;
  endtask

  task automatic wait_frame();
    int r0;
    r0 = n_rdy;
    for (int k = 0; k < 3000 && n_rdy == r0; k++) @(posedge clkin);
    check("frame_done", 32'(n_rdy != r0), 1);
    repeat (3) @(posedge clkin);
  endtask

  initial begin
    int ovr0, rdy0, vld0, tmo0, hit;
    logic [3:0] sl_exp;
    rst = 1'b1; dsp_conv_bar = 1'b1;
    for (int c = 0; c < CHIP_NO; c++) dur[c] = 10;
    repeat (3) @(posedge clkin);
    #1;
    sl_exp = '0;
    for (int i = 0; i < CH_NUM; i++) sl_exp[i] = 1'b1;
    check("rst_conv", 32'(ad_conv_bar), 1);
    check("rst_cs", 32'(ad_cs_bar), 32'({CHIP_NO{1'b1}}));
    check("rst_rd", 32'(ad_rd_bar), 1);
    check("rst_data", 32'(smp_data), 0);
    check("rst_tags", 32'({smp_chip, smp_ch}), 0);
    check("rst_strobes", 32'({smp_vld, db_rdy, seq_busy, err_ovr, err_tmo}), 0);
    check("ad_sl", 32'(ad_sl), 32'(sl_exp));
    rst = 1'b0;

    // Nominal frame with latency and busy-flag checks
    do_req(1'b1);
    check("seq_busy_run", 32'(seq_busy), 1);
    wait_frame();
    check("seq_busy_idle", 32'(seq_busy), 0);

    // Randomised BUSY durations and data
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < CHIP_NO; c++) dur[c] = $urandom_range(3, 25);
      do_req(1'b0);
      wait_frame();
    end
    check("no_ovr_yet", n_ovr, 0);

    // Overrun: second request mid-frame
    for (int c = 0; c < CHIP_NO; c++) dur[c] = 10;
    ovr0 = n_ovr; rdy0 = n_rdy;
    do_req(1'b0);
    repeat (20) @(posedge clkin);
    do_req(1'b0);
    wait_frame();
    repeat (20) @(posedge clkin);
    check("ovr_count", n_ovr - ovr0, 1);
    check("ovr_single_rdy", n_rdy - rdy0, 1);

    // Chip 3 BUSY lingers 50 cycles longer
    dur[3] = 60;
    do_req(1'b0);
    wait_frame();
    dur[3] = 10;

    // Reset during a chip 1 read
    do_req(1'b0);
    hit = 0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clkin); #1;
      if (!ad_cs_bar[1] && !ad_rd_bar) begin hit = 1; break; end
    end
    check("reach_chip1", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_cs", 32'(ad_cs_bar), 32'({CHIP_NO{1'b1}}));
    check("arst_strobes", 32'({ad_conv_bar, ad_rd_bar}), 3);
    check("arst_busy", 32'(seq_busy), 0);
    @(posedge clkin); #1 rst = 1'b0;
    rdy0 = n_rdy;
    repeat (60) @(posedge clkin);
    check("no_partial_rdy", n_rdy - rdy0, 0);
    do_req(1'b0);
    wait_frame();

`ifdef AD7864_TIMEOUT_EN
    for (int c = 0; c < CHIP_NO; c++) dur[c] = 0;
    tmo0 = n_tmo; vld0 = n_vld; rdy0 = n_rdy;
    do_req(1'b0);
    repeat (60) @(posedge clkin);
    check("tmo_pulse", n_tmo - tmo0, 1);
    check("tmo_no_smp", n_vld - vld0, 0);
    check("tmo_no_rdy", n_rdy - rdy0, 0);
    check("tmo_idle", 32'(seq_busy), 0);
    for (int c = 0; c < CHIP_NO; c++) dur[c] = 10;
    do_req(1'b0);
    wait_frame();
`else
    tmo0 = 0; vld0 = 0;
    check("tmo_never", n_tmo + tmo0 + vld0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
